sym_src_gen: RTL

Transmit-side symbol source and clock-enable generator for the 4-ASK chain. It derives the sample-rate and symbol-rate clock enables from the system clock. It produces one 18-bit 4-ASK symbol per symbol period from a PRBS or a test pattern, and drives the `in`, `sam_clk_en` and `sym_clk_en` inputs of the SRRC transmit pulse-shaping filter directly downstream. It also exports the transmitted dibit for a downstream BER checker.

---
 rtl/sym_src_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sym_src_gen.sv
// 4-ASK transmit symbol source: sample/symbol clock enables, PRBS or test pattern symbols,
// and the transmitted dibit for the BER checker.
module sym_src_gen #(
    parameter int          CLK_DIV = 4,
    parameter logic [21:0] SEED    = 22'h3FFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic               run,
    output logic               sam_clk_en,
    output logic               sym_clk_en,
    output logic signed [17:0] sym_out,
    output logic [1:0]         dibit_out
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    localparam logic signed [17:0] SYM_P2 = 18'sd98304;
    localparam logic signed [17:0] SYM_P1 = 18'sd32768;
    localparam logic signed [17:0] SYM_N1 = -18'sd32768;
    localparam logic signed [17:0] SYM_N2 = -18'sd98304;

    localparam logic [1:0] MODE_PRBS  = 2'd0;
    localparam logic [1:0] MODE_IMP   = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;

    logic [CW-1:0]      r_clk_cnt;
    logic [1:0]         r_sam_cnt;
    logic [21:0]        r_lfsr;
    logic               r_imp_done;

    logic               w_cnt_last;
    logic               w_f1;
    logic               w_f2;
    logic [21:0]        w_lfsr_nxt;
    logic               w_imp_nxt;
    logic signed [17:0] w_sym_nxt;
    logic [1:0]         w_dibit_nxt;

    assign w_cnt_last = (r_clk_cnt == CNT_LAST);

    // Two Fibonacci steps of x^22+x^21+1 unrolled; the second feedback uses the shifted state.
    assign w_f1 = r_lfsr[21] ^ r_lfsr[20];
    assign w_f2 = r_lfsr[20] ^ r_lfsr[19];

    function automatic logic signed [17:0] gray_map(input logic [1:0] d);
        logic signed [17:0] s;
        case (d)
            2'b00:   s = SYM_N2;
            2'b01:   s = SYM_N1;
            2'b11:   s = SYM_P1;
            default: s = SYM_P2;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_cnt  <= '0;
            r_sam_cnt  <= 2'd0;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
        end else begin
            r_clk_cnt  <= w_cnt_last ? '0 : r_clk_cnt + 1'b1;
            if (w_cnt_last) begin
                r_sam_cnt <= r_sam_cnt + 2'd1;
            end
            sam_clk_en <= w_cnt_last;
            // Symbol pulse rides on sample 0, so the very first sample pulse is also a symbol pulse.
            sym_clk_en <= w_cnt_last && (r_sam_cnt == 2'd0);
        end
    end

    always_comb begin
        w_sym_nxt   = '0;
        w_dibit_nxt = 2'b00;
        w_lfsr_nxt  = r_lfsr;
        w_imp_nxt   = r_imp_done && (mode == MODE_IMP);
        if (run) begin
            case (mode)
                MODE_PRBS: begin
                    w_dibit_nxt = {w_f1, w_f2};
                    w_lfsr_nxt  = {r_lfsr[19:0], w_f1, w_f2};
                    w_sym_nxt   = gray_map({w_f1, w_f2});
                end
                MODE_IMP: begin
                    w_sym_nxt = r_imp_done ? 18'sd0 : SYM_P2;
                    w_imp_nxt = 1'b1;
                end
                MODE_CONST: begin
                    w_sym_nxt = SYM_P1;
                end
                MODE_ALT: begin
                    w_sym_nxt = (sym_out == SYM_P2) ? SYM_N2 : SYM_P2;
                end
                default: begin
                    w_sym_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr     <= SEED;
            r_imp_done <= 1'b0;
            sym_out    <= '0;
            dibit_out  <= 2'b00;
        end else if (sym_clk_en) begin
            r_lfsr     <= w_lfsr_nxt;
            r_imp_done <= w_imp_nxt;
            sym_out    <= w_sym_nxt;
            dibit_out  <= w_dibit_nxt;
        end
    end

endmodule
